// File: rtl/sc_scbc_ulla_queue_if.sv
// sc_scbc_ulla_queue_if: SCBC register window plus ULLA low-level access port.
interface sc_scbc_ulla_queue_if #(parameter int ADDR_WIDTH = 32);
    logic                  WENB;
    logic [ADDR_WIDTH-1:0] WADR;
    logic [31:0]           WDAT;
    logic [3:0]            WBEN;
    logic                  RENB;
    logic [ADDR_WIDTH-1:0] RADR;
    logic [31:0]           RDAT;
    logic                  ULLA_ISR;
    logic                  ULLA_REQ;
    logic                  ULLA_ACK;
    logic [7:0]            ULLA_ADDR;
    logic                  ULLA_WR0RD1;
    logic [7:0]            ULLA_WRDATA;
    logic [7:0]            URC_DATA;
    modport slave (
        input  WENB, WADR, WDAT, WBEN, RENB, RADR, ULLA_ACK, URC_DATA,
        output RDAT, ULLA_ISR, ULLA_REQ, ULLA_ADDR, ULLA_WR0RD1, ULLA_WRDATA
    );
    modport master (
        output WENB, WADR, WDAT, WBEN, RENB, RADR, ULLA_ACK, URC_DATA,
        input  RDAT, ULLA_ISR, ULLA_REQ, ULLA_ADDR, ULLA_WR0RD1, ULLA_WRDATA
    );
endinterface

// File: rtl/sc_scbc_ulla_queue.sv
// sc_scbc_ulla_queue: queued ULPI register access engine with command and read-data FIFOs.
module sc_scbc_ulla_queue #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DEPTH          = 4,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h40
) (
    input logic                   ULPICLK,
    input logic                   ULPIRST,
    sc_scbc_ulla_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] A_STS  = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_RDQ  = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = BASE_ADDR + ADDR_WIDTH'(12);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state, state_nx;
    logic [16:0] cmd_q [DEPTH];
    logic [7:0] rd_q [DEPTH];
    logic [PW-1:0] cmd_wp, cmd_rp, rd_wp, rd_rp;
    logic [CW-1:0] cmd_cnt, rd_cnt;
    logic [TW-1:0] tmr;
    logic ovf, tout, done, udf, ien_done, ien_err, busy;
    logic [16:0] head;
    logic [31:0] sts_val, rdat_nx, rdat;
    logic isr, wr0rd1;
    logic [7:0] addr, wrdata;
    logic cmd_wr, sts_wr, ctrl_wr, rdq_rd, flush, push_cmd, pop_cmd, push_rd, pop_rd;
    logic launch, acked, timed_out;
    logic unused_bits;
    assign cmd_wr    = bus.WENB && bus.WADR == BASE_ADDR && &bus.WBEN[2:0];
    assign sts_wr    = bus.WENB && bus.WADR == A_STS && bus.WBEN[2];
    assign ctrl_wr   = bus.WENB && bus.WADR == A_CTRL && bus.WBEN[0];
    assign flush     = ctrl_wr && bus.WDAT[2];
    assign rdq_rd    = bus.RENB && bus.RADR == A_RDQ;
    assign push_cmd  = cmd_wr && !flush && cmd_cnt != CW'(DEPTH);
    // An empty queue lets a fresh CMD write issue on the very next cycle.
    assign head      = cmd_cnt != '0 ? cmd_q[cmd_rp] : bus.WDAT[16:0];
    assign launch    = (cmd_cnt != '0 || push_cmd) && (!head[16] || rd_cnt != CW'(DEPTH));
    assign acked     = state == REQ && bus.ULLA_ACK;
    assign timed_out = state == REQ && !bus.ULLA_ACK && tmr == TW'(TIMEOUT_CYCLES - 1);
    assign pop_cmd   = acked || timed_out;
    assign push_rd   = acked && wr0rd1 && !flush;
    assign pop_rd    = rdq_rd && rd_cnt != '0;
    assign busy      = state != IDLE || cmd_cnt != '0;
    assign sts_val   = {11'b0, udf, done, tout, ovf, busy, 6'b0, 5'(rd_cnt), 5'(cmd_cnt)};
    assign unused_bits = ^{bus.WDAT[31:21], bus.WBEN[3]};
    always_comb begin
        state_nx = flush ? IDLE :
                   state == IDLE ? (launch ? REQ : IDLE) :
                   state == REQ ? (pop_cmd ? GAP : REQ) : IDLE;
        rdat_nx  = bus.RADR == A_STS ? sts_val :
                   bus.RADR == A_RDQ ? (rd_cnt != '0 ? {23'b0, 1'b1, rd_q[rd_rp]} : 32'b0) :
                   bus.RADR == A_CTRL ? {30'b0, ien_err, ien_done} : 32'b0;
    end
    always_ff @(posedge ULPICLK) begin
        if (push_cmd) cmd_q[cmd_wp] <= bus.WDAT[16:0];
        if (push_rd) rd_q[rd_wp] <= bus.URC_DATA;
    end
    always_ff @(posedge ULPICLK or posedge ULPIRST) begin
        if (ULPIRST) begin
            state    <= IDLE;
            cmd_wp   <= '0;
            cmd_rp   <= '0;
            rd_wp    <= '0;
            rd_rp    <= '0;
            cmd_cnt  <= '0;
            rd_cnt   <= '0;
            tmr      <= '0;
            ovf      <= 1'b0;
            tout     <= 1'b0;
            done     <= 1'b0;
            udf      <= 1'b0;
            ien_done <= 1'b0;
            ien_err  <= 1'b0;
            isr      <= 1'b0;
            rdat     <= '0;
            addr     <= '0;
            wrdata   <= '0;
            wr0rd1   <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= state == REQ ? tmr + TW'(1) : '0;
            if (state == IDLE && state_nx == REQ) {wr0rd1, wrdata, addr} <= head;
            if (flush) begin
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                rd_wp   <= '0;
                rd_rp   <= '0;
                cmd_cnt <= '0;
                rd_cnt  <= '0;
            end else begin
                cmd_wp  <= cmd_wp + PW'(push_cmd);
                cmd_rp  <= cmd_rp + PW'(pop_cmd);
                rd_wp   <= rd_wp + PW'(push_rd);
                rd_rp   <= rd_rp + PW'(pop_rd);
                cmd_cnt <= cmd_cnt + CW'(push_cmd) - CW'(pop_cmd);
                rd_cnt  <= rd_cnt + CW'(push_rd) - CW'(pop_rd);
            end
            // Hardware sets take priority over a simultaneous W1C clear.
            ovf  <= (ovf  & ~(sts_wr & bus.WDAT[17])) | (cmd_wr && cmd_cnt == CW'(DEPTH));
            tout <= (tout & ~(sts_wr & bus.WDAT[18])) | (timed_out && !flush);
            done <= (done & ~(sts_wr & bus.WDAT[19])) | (acked && !flush);
            udf  <= (udf  & ~(sts_wr & bus.WDAT[20])) | (rdq_rd && rd_cnt == '0);
            if (ctrl_wr) {ien_err, ien_done} <= bus.WDAT[1:0];
            isr <= (done & ien_done) | ((ovf | tout | udf) & ien_err);
            if (bus.RENB) rdat <= rdat_nx;
        end
    end
    assign bus.RDAT        = rdat;
    assign bus.ULLA_ISR    = isr;
    assign bus.ULLA_REQ    = state == REQ;
    assign bus.ULLA_ADDR   = addr;
    assign bus.ULLA_WRDATA = wrdata;
    assign bus.ULLA_WR0RD1 = wr0rd1;
endmodule

// File: tb/tb_sc_scbc_ulla_queue.sv
// tb_sc_scbc_ulla_queue: scenario tasks plus a randomized queue-model run for the ULLA queue engine.
module tb_sc_scbc_ulla_queue;
    localparam int DEPTH = 4;
    localparam int TO = 16;
    localparam logic [31:0] B = 32'h40;
    typedef struct {logic [7:0] a; logic [7:0] w; logic r;} cmd_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] d;
    logic [7:0] x;
    bit ok;
    logic [7:0] exp_rdq [$];
    always #5 clk = ~clk;
    sc_scbc_ulla_queue_if #(.ADDR_WIDTH(32)) bus();
    sc_scbc_ulla_queue #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .BASE_ADDR(B))
        dut (.ULPICLK(clk), .ULPIRST(rst), .bus(bus));

    function automatic logic [31:0] sts(int c, int r, bit bz, bit ov, bit to, bit dn, bit uf);
        return {11'b0, uf, dn, to, ov, bz, 6'b0, 5'(r), 5'(c)};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
        bus.WENB = 1'b1; bus.WADR = a; bus.WDAT = v; bus.WBEN = be;
        @(negedge clk);
        bus.WENB = 1'b0; bus.WBEN = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.RENB = 1'b1; bus.RADR = a;
        @(negedge clk);
        bus.RENB = 1'b0;
        v = bus.RDAT;
    endtask

    task automatic ack(input logic [7:0] v);
        bus.ULLA_ACK = 1'b1; bus.URC_DATA = v;
        @(negedge clk);
        bus.ULLA_ACK = 1'b0; bus.URC_DATA = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(output bit f);
        f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ULLA_REQ) begin f = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic clear_flags();
        wr(B + 4, 32'h001E_0000, 4'hF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_chk++;
        if ({bus.ULLA_REQ, bus.ULLA_ISR, bus.RDAT, bus.ULLA_ADDR, bus.ULLA_WRDATA, bus.ULLA_WR0RD1} !== '0)
            $display("FAIL reset_outputs req=%b isr=%b rdat=%h", bus.ULLA_REQ, bus.ULLA_ISR, bus.RDAT);
        else n_pass++;
        rst = 1'b0;
        idle(1);
        rd(B + 4, d);
        n_chk++; if (d !== 32'h0) $display("FAIL reset_sts got=%h exp=0", d); else n_pass++;
        rd(B + 12, d);
        n_chk++; if (d !== 32'h0) $display("FAIL reset_ctrl got=%h exp=0", d); else n_pass++;
    endtask

    task automatic test_write();
        wr(B + 12, 32'h1, 4'hF);
        wr(B, 32'h0000_550A, 4'h7);
        n_chk++;
        if ({bus.ULLA_REQ, bus.ULLA_WR0RD1, bus.ULLA_WRDATA, bus.ULLA_ADDR} !== {1'b1, 1'b0, 8'h55, 8'h0A})
            $display("FAIL write_issue req=%b rd=%b data=%h addr=%h exp 1 0 55 0a",
                     bus.ULLA_REQ, bus.ULLA_WR0RD1, bus.ULLA_WRDATA, bus.ULLA_ADDR);
        else n_pass++;
        idle(2);
        n_chk++; if (bus.ULLA_REQ !== 1'b1) $display("FAIL write_req_hold got=%b exp=1", bus.ULLA_REQ); else n_pass++;
        ack(8'hEE);
        n_chk++; if (bus.ULLA_REQ !== 1'b0) $display("FAIL write_req_fall got=%b exp=0", bus.ULLA_REQ); else n_pass++;
        idle(1);
        n_chk++; if (bus.ULLA_ISR !== 1'b1) $display("FAIL write_isr got=%b exp=1", bus.ULLA_ISR); else n_pass++;
        rd(B + 4, d);
        n_chk++; if (d !== sts(0, 0, 0, 0, 0, 1, 0)) $display("FAIL write_sts got=%h exp=%h", d, sts(0, 0, 0, 0, 0, 1, 0)); else n_pass++;
        wr(B + 4, 32'h0008_0000, 4'hF);
        idle(1);
        n_chk++; if (bus.ULLA_ISR !== 1'b0) $display("FAIL write_isr_clear got=%b exp=0", bus.ULLA_ISR); else n_pass++;
        wr(B + 12, 32'h0, 4'hF);
    endtask

    task automatic test_overflow();
        clear_flags();
        for (int i = 0; i < 5; i++) wr(B, {15'b0, 1'b1, 8'h00, 8'(i)}, 4'h7);
        rd(B + 4, d);
        n_chk++; if (d !== sts(4, 0, 1, 1, 0, 0, 0)) $display("FAIL ovf_sts got=%h exp=%h", d, sts(4, 0, 1, 1, 0, 0, 0)); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            n_chk++;
            if (!ok || bus.ULLA_ADDR !== 8'(i) || bus.ULLA_WR0RD1 !== 1'b1)
                $display("FAIL ovf_issue%0d req=%b addr=%h rd=%b exp addr=%h rd=1", i, ok, bus.ULLA_ADDR, bus.ULLA_WR0RD1, 8'(i));
            else n_pass++;
            x = 8'(8'h11 + i);
            ack(x);
            exp_rdq.push_back(x);
        end
        idle(1);
        while (exp_rdq.size() > 0) begin
            rd(B + 8, d);
            n_chk++; if (d !== {23'b0, 1'b1, exp_rdq[0]}) $display("FAIL ovf_pop got=%h exp=%h", d, {23'b0, 1'b1, exp_rdq[0]}); else n_pass++;
            void'(exp_rdq.pop_front());
        end
        rd(B + 8, d);
        n_chk++; if (d !== 32'h0) $display("FAIL udf_pop got=%h exp=0", d); else n_pass++;
        rd(B + 4, d);
        n_chk++; if (d !== sts(0, 0, 0, 1, 0, 1, 1)) $display("FAIL udf_sts got=%h exp=%h", d, sts(0, 0, 0, 1, 0, 1, 1)); else n_pass++;
    endtask

    task automatic test_rd_full();
        clear_flags();
        for (int i = 0; i < DEPTH; i++) begin
            wr(B, {15'b0, 1'b1, 8'h00, 8'(8'h20 + i)}, 4'h7);
            wait_req(ok);
            x = 8'($urandom);
            ack(x);
            exp_rdq.push_back(x);
        end
        wr(B, {15'b0, 1'b1, 8'h00, 8'h30}, 4'h7);
        idle(4);
        n_chk++; if (bus.ULLA_REQ !== 1'b0) $display("FAIL full_stall req=%b exp=0", bus.ULLA_REQ); else n_pass++;
        rd(B + 4, d);
        n_chk++; if (d !== sts(1, 4, 1, 0, 0, 1, 0)) $display("FAIL full_sts got=%h exp=%h", d, sts(1, 4, 1, 0, 0, 1, 0)); else n_pass++;
        rd(B + 8, d);
        n_chk++; if (d !== {23'b0, 1'b1, exp_rdq[0]}) $display("FAIL full_pop got=%h exp=%h", d, {23'b0, 1'b1, exp_rdq[0]}); else n_pass++;
        void'(exp_rdq.pop_front());
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.ULLA_REQ) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok || bus.ULLA_ADDR !== 8'h30) $display("FAIL full_resume req=%b addr=%h exp 1 30", ok, bus.ULLA_ADDR); else n_pass++;
        x = 8'($urandom);
        ack(x);
        exp_rdq.push_back(x);
        idle(1);
        while (exp_rdq.size() > 0) begin
            rd(B + 8, d);
            n_chk++; if (d !== {23'b0, 1'b1, exp_rdq[0]}) $display("FAIL full_drain got=%h exp=%h", d, {23'b0, 1'b1, exp_rdq[0]}); else n_pass++;
            void'(exp_rdq.pop_front());
        end
    endtask

    task automatic test_timeout();
        int cnt;
        int lo;
        wr(B + 12, 32'h2, 4'hF);
        clear_flags();
        cnt = 0;
        wr(B, 32'h0000_A53C, 4'h7);
        if (bus.ULLA_REQ) cnt++;
        wr(B, 32'h0000_5A3D, 4'h7);
        if (bus.ULLA_REQ) cnt++;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.ULLA_REQ) break;
            cnt++;
        end
        n_chk++; if (cnt !== TO) $display("FAIL tout_len got=%0d exp=%0d", cnt, TO); else n_pass++;
        lo = 1;
        while (!bus.ULLA_REQ && lo < 6) begin @(negedge clk); if (!bus.ULLA_REQ) lo++; end
        n_chk++; if (lo !== 2) $display("FAIL tout_gap got=%0d exp=2", lo); else n_pass++;
        n_chk++;
        if ({bus.ULLA_REQ, bus.ULLA_ADDR, bus.ULLA_WRDATA} !== {1'b1, 8'h3D, 8'h5A})
            $display("FAIL tout_next req=%b addr=%h data=%h exp 1 3d 5a", bus.ULLA_REQ, bus.ULLA_ADDR, bus.ULLA_WRDATA);
        else n_pass++;
        ack(8'h99);
        idle(1);
        rd(B + 4, d);
        n_chk++; if (d !== sts(0, 0, 0, 0, 1, 1, 0)) $display("FAIL tout_sts got=%h exp=%h", d, sts(0, 0, 0, 0, 1, 1, 0)); else n_pass++;
        n_chk++; if (bus.ULLA_ISR !== 1'b1) $display("FAIL tout_isr got=%b exp=1", bus.ULLA_ISR); else n_pass++;
        clear_flags();
        idle(1);
        n_chk++; if (bus.ULLA_ISR !== 1'b0) $display("FAIL tout_isr_clear got=%b exp=0", bus.ULLA_ISR); else n_pass++;
        wr(B + 12, 32'h0, 4'hF);
    endtask

    task automatic test_random();
        cmd_t q [$];
        cmd_t c;
        int n;
        clear_flags();
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                c.a = 8'($urandom); c.w = 8'($urandom); c.r = 1'($urandom_range(0, 1));
                q.push_back(c);
                wr(B, {15'b0, c.r, c.w, c.a}, 4'h7);
            end
            while (q.size() > 0) begin
                if (exp_rdq.size() > 0 && (exp_rdq.size() == DEPTH || $urandom_range(0, 1) == 1)) begin
                    rd(B + 8, d);
                    n_chk++; if (d !== {23'b0, 1'b1, exp_rdq[0]}) $display("FAIL rnd_pop got=%h exp=%h", d, {23'b0, 1'b1, exp_rdq[0]}); else n_pass++;
                    void'(exp_rdq.pop_front());
                end
                wait_req(ok);
                n_chk++;
                if (!ok || {bus.ULLA_WR0RD1, bus.ULLA_WRDATA, bus.ULLA_ADDR} !== {q[0].r, q[0].w, q[0].a})
                    $display("FAIL rnd_issue req=%b got=%b_%h_%h exp=%b_%h_%h", ok, bus.ULLA_WR0RD1, bus.ULLA_WRDATA,
                             bus.ULLA_ADDR, q[0].r, q[0].w, q[0].a);
                else n_pass++;
                idle($urandom_range(0, 4));
                x = 8'($urandom);
                ack(x);
                if (q[0].r) exp_rdq.push_back(x);
                void'(q.pop_front());
            end
        end
        idle(2);
        rd(B + 4, d);
        n_chk++; if (d !== sts(0, exp_rdq.size(), 0, 0, 0, 1, 0)) $display("FAIL rnd_sts got=%h exp=%h", d, sts(0, exp_rdq.size(), 0, 0, 0, 1, 0)); else n_pass++;
        while (exp_rdq.size() > 0) begin
            rd(B + 8, d);
            n_chk++; if (d !== {23'b0, 1'b1, exp_rdq[0]}) $display("FAIL rnd_drain got=%h exp=%h", d, {23'b0, 1'b1, exp_rdq[0]}); else n_pass++;
            void'(exp_rdq.pop_front());
        end
    endtask

    task automatic test_flush();
        clear_flags();
        wr(B, 32'h0001_0001, 4'h7);
        wr(B, 32'h0001_0002, 4'h7);
        wr(B, 32'h0000_1103, 4'h7);
        n_chk++; if (bus.ULLA_REQ !== 1'b1 || bus.ULLA_ADDR !== 8'h01) $display("FAIL flush_pre req=%b addr=%h exp 1 01", bus.ULLA_REQ, bus.ULLA_ADDR); else n_pass++;
        wr(B + 12, 32'h4, 4'hF);
        n_chk++; if (bus.ULLA_REQ !== 1'b0) $display("FAIL flush_req got=%b exp=0", bus.ULLA_REQ); else n_pass++;
        ack(8'h77);
        idle(1);
        rd(B + 4, d);
        n_chk++; if (d !== 32'h0) $display("FAIL flush_sts got=%h exp=0", d); else n_pass++;
        idle(3);
        n_chk++; if (bus.ULLA_REQ !== 1'b0) $display("FAIL flush_quiet req=%b exp=0", bus.ULLA_REQ); else n_pass++;
        rd(B + 8, d);
        n_chk++; if (d !== 32'h0) $display("FAIL flush_rdq got=%h exp=0", d); else n_pass++;
    endtask

    task automatic test_async_reset();
        wr(B + 12, 32'h1, 4'hF);
        clear_flags();
        wr(B, 32'h0000_0110, 4'h7);
        wait_req(ok);
        ack(8'h00);
        idle(1);
        n_chk++; if (bus.ULLA_ISR !== 1'b1) $display("FAIL arst_isr_pre got=%b exp=1", bus.ULLA_ISR); else n_pass++;
        wr(B, 32'h0001_0011, 4'h7);
        rd(B + 4, d);
        n_chk++; if (d !== sts(1, 0, 1, 0, 0, 1, 0)) $display("FAIL arst_sts_pre got=%h exp=%h", d, sts(1, 0, 1, 0, 0, 1, 0)); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.ULLA_REQ, bus.ULLA_ISR, bus.RDAT} !== '0)
            $display("FAIL arst_outputs req=%b isr=%b rdat=%h exp 0", bus.ULLA_REQ, bus.ULLA_ISR, bus.RDAT);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        rd(B + 4, d);
        n_chk++; if (d !== 32'h0) $display("FAIL arst_sts got=%h exp=0", d); else n_pass++;
    endtask

    initial begin
        bus.WENB = 1'b0; bus.WADR = '0; bus.WDAT = '0; bus.WBEN = '0;
        bus.RENB = 1'b0; bus.RADR = '0; bus.ULLA_ACK = 1'b0; bus.URC_DATA = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_overflow();
        test_rd_full();
        test_timeout();
        test_random();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1);
    end
endmodule

// File: doc/sc_scbc_ulla_queue.md
Name: sc_scbc_ulla_queue

Overview:
Queued ULPI low-level register access engine for the SCBC. Firmware pushes up to DEPTH ULPI register read/write commands through a register window. An FSM issues them one at a time on the ULLA req/ack handshake. Read results go into a read-data FIFO that firmware pops. The block adds a per-command timeout, sticky error flags, a flush control and an interrupt; it sits between the SCBC register bus and the ULPI port controller's low-level access port.

Parameters:
ADDR_WIDTH, 32, register address width
DEPTH, 4, command FIFO and read-data FIFO depth (power of 2, 2..16)
TIMEOUT_CYCLES, 1024, ULPICLK cycles REQ may stay high before the command is abandoned (>=4)
BASE_ADDR, 'h40, byte address of CMD register; STS=+4, RDQ=+8, CTRL=+'hC

Ports:
ULPICLK  in  1  ULPI clock, sole clock
ULPIRST  in  1  asynchronous active-high reset
WENB  in  1  register write enable
WADR  in  ADDR_WIDTH  write address
WDAT  in  32  write data
WBEN  in  4  write byte enables
RENB  in  1  register read enable
RADR  in  ADDR_WIDTH  read address
RDAT  out  32  registered read data
ULLA_ISR  out  1  interrupt
ULLA_REQ  out  1  access request
ULLA_ACK  in  1  access complete, 1-cycle pulse
ULLA_ADDR  out  8  ULPI register address
ULLA_WR0RD1  out  1  0=write, 1=read
ULLA_WRDATA  out  8  ULPI write data
URC_DATA  in  8  ULPI read data, valid with ULLA_ACK

Behaviour:
- Reset: one clock, ULPICLK; reset ULPIRST is asynchronous and active-high. All outputs are 0, both FIFOs are empty, FSM is IDLE, all flags and enables are 0.
- CMD (W): [7:0] addr, [15:8] wrData, [16] wr0rd1.
  - A write with WBEN[2:0] all set pushes one entry.
  - If the FIFO is full (count sampled before this cycle's pop), the entry is dropped and STS.ovf is set.
- STS (R):
  - [4:0] cmdCount, [9:5] rdCount, [16] busy (FSM != IDLE or cmdCount != 0).
  - Sticky bits: [17] ovf, [18] tout, [19] done (set after each completed command), [20] udf.
  - Write 1 to clear the sticky bits. If a hardware set and a W1C clear occur in the same cycle, set wins.
- RDQ (R):
  - [7:0] data, [8] valid.
  - A read hit pops one entry. RDAT reflects the popped head.
  - A read when the FIFO is empty returns 0 and sets udf.
- CTRL (R/W): [0] ienDone, [1] ienErr, [2] flush (write-1 strobe, reads 0).
- ULLA_ISR = (done & ienDone) | ((ovf | tout | udf) & ienErr). It is registered, so it asserts 1 cycle after the flag is set.
- RDAT: updated the cycle after RENB. Unmapped addresses return 0. RDAT holds its value when RENB=0.
- FSM states:
  - IDLE: if cmdCount != 0 and (head is a write or rdCount < DEPTH), latch the head fields to ULLA_* → REQ. A read blocked by a full read-data FIFO stalls in IDLE; nothing is dropped.
  - REQ: ULLA_REQ=1 and ULLA_* are stable.
    - On ULLA_ACK: pop the command; if it was a read, push URC_DATA; set done → GAP.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 without ACK: pop the command, set tout, push nothing → GAP.
  - GAP: ULLA_REQ=0 for exactly one cycle → IDLE. ULLA_ACK seen in GAP or IDLE is ignored.
- Timing and ordering:
  - Timeout counter clears on entry to REQ.
  - Earliest REQ is the cycle after the CMD write.
  - Back-to-back commands leave ≥1 REQ-low cycle between them.
  - ULLA_ADDR/WRDATA/WR0RD1 hold their last value outside REQ.
- Flush:
  - Empties both FIFOs and forces the FSM to IDLE next cycle, dropping ULLA_REQ even mid-REQ; a late ACK is ignored.
  - Flush does not change sticky flags.
  - A CMD push in the same cycle as a flush is discarded.
- Concurrency: a CMD push and an engine pop in the same cycle are both honoured; a RDQ pop and an engine push in the same cycle are both honoured. Counts stay exact.
- Reset mid-operation: ULLA_REQ drops immediately (async) and the queue is lost.

Test Plan:
- Push write {addr=0x0A, data=0x55, wr} → REQ rises next cycle with ULLA_ADDR=0x0A, WRDATA=0x55, WR0RD1=0. ACK after 3 cycles → REQ falls, done=1, ISR=1 if ienDone. Then clear done via W1C → ISR returns to 0.
- DEPTH=4, push 5 reads with ACK held off → cmdCount=4, ovf=1. Then ACK each with URC_DATA 0x11..0x14 → 4 RDQ pops return 0x111..0x114 (valid=1), a 5th pop returns 0 and sets udf.
- Fill the read FIFO (4 entries), queue a 5th read → FSM stays IDLE, REQ=0, cmdCount=1. One RDQ pop → REQ asserts within 2 cycles.
- Leave ACK low for TIMEOUT_CYCLES=16 → REQ falls after exactly 16 REQ cycles, tout=1, no RDQ entry. The next queued command issues after the 1-cycle GAP.
- Queue 3 commands, flush during the first REQ → REQ=0 next cycle, cmdCount=0, busy=0. A late ACK produces no RDQ entry and does not set done.
- Assert ULPIRST asynchronously mid-REQ → ULLA_REQ, ULLA_ISR and RDAT go to 0 without a clock edge, and STS reads 0 after release.
